// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and default operand width for the adder arbiter slice
package adder_pkg;
    typedef enum logic {IDLE, LOCK} arb_state_t;
    localparam int DEF_D_WIDTH = 32;
endpackage

// File: rtl/lca.sv
// lca: lookahead-carry adder, {c_o, s_o} = a_i + b_i + c_i
module lca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);
    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   c;
    assign g = a_i & b_i;
    assign p = a_i ^ b_i;
    always_comb begin
        c[0] = c_i;
        for (int k = 0; k < WIDTH; k++) c[k+1] = g[k] | (p[k] & c[k]);
    end
    assign s_o = p ^ c[WIDTH-1:0];
    assign c_o = c[WIDTH];
endmodule

// File: rtl/rr_arb.sv
// rr_arb: round-robin priority select starting at ptr_i, or the locked owner only
module rr_arb #(
    parameter int N_REQ = 4,
    localparam int ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    input  logic                lock_i,
    input  logic [ID_WIDTH-1:0] owner_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [ID_WIDTH-1:0] idx_o
);
    logic found;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        if (lock_i) begin
            gnt_o[owner_i] = req_i[owner_i];
            idx_o          = owner_i;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req_i[(int'(ptr_i) + k) % N_REQ]) begin
                    found = 1'b1;
                    gnt_o[(int'(ptr_i) + k) % N_REQ] = 1'b1;
                    idx_o = ID_WIDTH'((int'(ptr_i) + k) % N_REQ);
                end
            end
        end
    end
endmodule

// File: rtl/adder_arb.sv
// adder_arb: round-robin sharing of one lca adder with chained multi-beat carries
module adder_arb
    import adder_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int N_REQ   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ*D_WIDTH-1:0]   req_a_i,
    input  logic [N_REQ*D_WIDTH-1:0]   req_b_i,
    input  logic [N_REQ-1:0]           req_c_i,
    input  logic [N_REQ-1:0]           req_last_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
    output logic [D_WIDTH-1:0]         rsp_s_o,
    output logic                       rsp_c_o,
    output logic                       rsp_last_o
);
    localparam int ID_WIDTH = $clog2(N_REQ);

    arb_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d, owner_q, owner_d, sel;
    logic                carry_q, carry_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_c_q, rsp_c_d, rsp_last_q, rsp_last_d;
    logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic [D_WIDTH-1:0]  rsp_s_q, rsp_s_d, sum;
    logic [N_REQ-1:0]    gnt;
    logic                can_accept, acc, cin, cout, last_sel;

    rr_arb #(.N_REQ(N_REQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .lock_i  (state_q == LOCK),
        .owner_i (owner_q),
        .gnt_o   (gnt),
        .idx_o   (sel)
    );

    assign can_accept  = !rsp_valid_q || rsp_ready_i;
    assign req_ready_o = (can_accept && !rst_i) ? gnt : '0;
    assign acc         = |req_ready_o;
    assign last_sel    = req_last_i[sel];
    // Chain carry replaces the requester's carry-in on every beat after the first
    assign cin         = (state_q == LOCK) ? carry_q : req_c_i[sel];

    lca #(.WIDTH(D_WIDTH)) u_lca (
        .a_i (req_a_i[sel*D_WIDTH +: D_WIDTH]),
        .b_i (req_b_i[sel*D_WIDTH +: D_WIDTH]),
        .c_i (cin),
        .s_o (sum),
        .c_o (cout)
    );

    always_comb begin
        state_d     = acc ? (last_sel ? IDLE : LOCK) : state_q;
        owner_d     = (acc && !last_sel) ? sel : owner_q;
        carry_d     = (acc && !last_sel) ? cout : carry_q;
        ptr_d       = (acc && last_sel) ? ((int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1) : ptr_q;
        rsp_valid_d = acc || (rsp_valid_q && !rsp_ready_i);
        rsp_id_d    = acc ? sel : rsp_id_q;
        rsp_s_d     = acc ? sum : rsp_s_q;
        rsp_c_d     = acc ? cout : rsp_c_q;
        rsp_last_d  = acc ? last_sel : rsp_last_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_c_q     <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_c_q     <= rsp_c_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_s_o     = rsp_s_q;
    assign rsp_c_o     = rsp_c_q;
    assign rsp_last_o  = rsp_last_q;
endmodule
